// File: rtl/mmu_pkg.sv
// Shared MMU definitions: TileLink-UL opcodes, PTE tag width,
// PTE cache FSM states and the request/response bundles it registers.
package mmu_pkg;

  localparam logic [2:0] TL_GET        = 3'd4;
  localparam logic [2:0] TL_PUTFULL    = 3'd0;
  localparam logic [2:0] TL_PUTPARTIAL = 3'd1;
  localparam logic [2:0] TL_ACK        = 3'd0;
  localparam logic [2:0] TL_ACKDATA    = 3'd1;

  localparam int PTE_TAG_W = 30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT_RESP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } a_req_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } d_rsp_t;

  function automatic logic is_put(input logic [2:0] op);
    return (op == TL_PUTFULL) || (op == TL_PUTPARTIAL);
  endfunction

endpackage

// File: rtl/pte_cache_array.sv
// PTE storage: valid/tag/data per entry, FIFO fill pointer, parallel
// tag compare. Ports: lookup (hit/hit_data), kill (tag), fill, clear.
module pte_cache_array
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PTE_TAG_W-1:0] lookup_tag,
  output logic                 hit,
  output logic [31:0]          hit_data,
  input  logic                 kill,
  input  logic [PTE_TAG_W-1:0] kill_tag,
  input  logic                 fill,
  input  logic [PTE_TAG_W-1:0] fill_tag,
  input  logic [31:0]          fill_data,
  input  logic                 clear
);

  localparam int PW = $clog2(ENTRIES);

  logic [ENTRIES-1:0]   valid;
  logic [PTE_TAG_W-1:0] tags  [ENTRIES];
  logic [31:0]          datas [ENTRIES];
  logic [PW-1:0]        ptr;
  logic [ENTRIES-1:0]   match;

  // Tags are unique among valid entries, so OR-ing is a clean mux.
  always_comb begin
    match    = '0;
    hit_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid[i] && (tags[i] == lookup_tag);
      if (match[i]) hit_data = hit_data | datas[i];
    end
  end

  assign hit = |match;

  // Clear beats fill; the pointer keeps its position across clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      ptr   <= '0;
    end else if (clear) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (kill && valid[i] && (tags[i] == kill_tag))
          valid[i] <= 1'b0;
      end
      if (fill) begin
        valid[ptr] <= 1'b1;
        ptr        <= ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill && !clear && !rst) begin
      tags[ptr]  <= fill_tag;
      datas[ptr] <= fill_data;
    end
  end

endmodule

// File: rtl/pte_cache.sv
// Fully-associative PTE cache between page walker (up) and memory (dn).
// Ports: clk/rst, inv_i, idle_o, up A/D TileLink-UL, dn A/D TileLink-UL.
module pte_cache
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_i,
  input  logic        inv_i,
  output logic        idle_o,
  input  logic [2:0]  up_a_opcode,
  input  logic [2:0]  up_a_param,
  input  logic [3:0]  up_a_size,
  input  logic [31:0] up_a_address,
  input  logic [3:0]  up_a_mask,
  input  logic [31:0] up_a_data,
  input  logic        up_a_corrupt,
  input  logic        up_a_valid,
  output logic        up_a_ready,
  output logic [2:0]  up_d_opcode,
  output logic [1:0]  up_d_param,
  output logic [3:0]  up_d_size,
  output logic        up_d_denied,
  output logic [31:0] up_d_data,
  output logic        up_d_corrupt,
  output logic        up_d_valid,
  input  logic        up_d_ready,
  output logic [2:0]  dn_a_opcode,
  output logic [2:0]  dn_a_param,
  output logic [3:0]  dn_a_size,
  output logic [31:0] dn_a_address,
  output logic [3:0]  dn_a_mask,
  output logic [31:0] dn_a_data,
  output logic        dn_a_corrupt,
  output logic        dn_a_valid,
  input  logic        dn_a_ready,
  input  logic [2:0]  dn_d_opcode,
  input  logic [1:0]  dn_d_param,
  input  logic [3:0]  dn_d_size,
  input  logic        dn_d_denied,
  input  logic [31:0] dn_d_data,
  input  logic        dn_d_corrupt,
  input  logic        dn_d_valid,
  output logic        dn_d_ready
);

  state_t state;
  a_req_t req;
  d_rsp_t rsp;
  logic   cacheable;
  logic   no_fill;

  logic        arr_hit;
  logic [31:0] arr_data;
  logic        a_cacheable;
  logic        hit_now;
  logic        kill;
  logic        fill;

  assign a_cacheable = (up_a_opcode == TL_GET)
                    && (up_a_size == 4'd2);
  assign hit_now = a_cacheable && arr_hit && !inv_i;

  assign kill = (state == S_IDLE) && up_a_valid
             && is_put(up_a_opcode);

  assign fill = (state == S_MISS_WAIT) && dn_d_valid
             && cacheable
             && (dn_d_opcode == TL_ACKDATA)
             && !dn_d_denied && !dn_d_corrupt
             && !no_fill && !inv_i;

  pte_cache_array #(
    .ENTRIES(ENTRIES)
  ) u_array (
    .clk       (cpu_clk_i),
    .rst       (cpu_rst_i),
    .lookup_tag(up_a_address[31:2]),
    .hit       (arr_hit),
    .hit_data  (arr_data),
    .kill      (kill),
    .kill_tag  (up_a_address[31:2]),
    .fill      (fill),
    .fill_tag  (req.address[31:2]),
    .fill_data (dn_d_data),
    .clear     (inv_i)
  );

  assign dn_a_opcode  = req.opcode;
  assign dn_a_param   = req.param;
  assign dn_a_size    = req.size;
  assign dn_a_address = req.address;
  assign dn_a_mask    = req.mask;
  assign dn_a_data    = req.data;
  assign dn_a_corrupt = req.corrupt;

  assign up_d_opcode  = rsp.opcode;
  assign up_d_param   = rsp.param;
  assign up_d_size    = rsp.size;
  assign up_d_denied  = rsp.denied;
  assign up_d_data    = rsp.data;
  assign up_d_corrupt = rsp.corrupt;

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state      <= S_IDLE;
      req        <= '0;
      rsp        <= '0;
      cacheable  <= 1'b0;
      no_fill    <= 1'b0;
      idle_o     <= 1'b1;
      up_a_ready <= 1'b1;
      up_d_valid <= 1'b0;
      dn_a_valid <= 1'b0;
      dn_d_ready <= 1'b0;
    end else begin
      // An invalidate while memory owns the request poisons its fill.
      if (inv_i && (state == S_MISS_REQ
                 || state == S_MISS_WAIT))
        no_fill <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (up_a_valid) begin
            req <= '{opcode:  up_a_opcode,
                     param:   up_a_param,
                     size:    up_a_size,
                     address: up_a_address,
                     mask:    up_a_mask,
                     data:    up_a_data,
                     corrupt: up_a_corrupt};
            cacheable  <= a_cacheable;
            idle_o     <= 1'b0;
            up_a_ready <= 1'b0;
            if (hit_now) begin
              rsp <= '{opcode:  TL_ACKDATA,
                       param:   2'd0,
                       size:    4'd2,
                       denied:  1'b0,
                       data:    arr_data,
                       corrupt: 1'b0};
              up_d_valid <= 1'b1;
              state      <= S_HIT_RESP;
            end else begin
              dn_a_valid <= 1'b1;
              state      <= S_MISS_REQ;
            end
          end
        end
        S_HIT_RESP, S_RESP: begin
          if (up_d_ready) begin
            up_d_valid <= 1'b0;
            idle_o     <= 1'b1;
            up_a_ready <= 1'b1;
            no_fill    <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_MISS_REQ: begin
          if (dn_a_ready) begin
            dn_a_valid <= 1'b0;
            dn_d_ready <= 1'b1;
            state      <= S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          if (dn_d_valid) begin
            rsp <= '{opcode:  dn_d_opcode,
                     param:   dn_d_param,
                     size:    dn_d_size,
                     denied:  dn_d_denied,
                     data:    dn_d_data,
                     corrupt: dn_d_corrupt};
            dn_d_ready <= 1'b0;
            up_d_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
